// File: rtl/clock_gen_pkg.sv
// Shared types and clamp helpers for the clock_gen multi-channel divider.
// Helpers work on 32-bit values; callers cast to their counter width.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 16;

    // Ratios of 0 and 1 cannot make a square wave, so they run as 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

    function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] d);
        return (phase > d - 32'd1) ? d - 32'd1 : phase;
    endfunction

    // Odd ratios spend the extra cycle high.
    function automatic logic [31:0] high_time(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clock_gen_ch.sv
// One clock_gen channel: config shadows, wrap counter and registered outclk/tick.
// Phase shadow exists only when CLOCK_GEN_PHASE_EN is defined.
module clock_gen_ch
    import clock_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(2)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] phase_i,
    input  logic             load_i,
    input  logic             run_i,
    output logic             outclk_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] d_eff, p_eff, hi;
    logic             outclk_q, outclk_d;
    logic             tick_q, tick_d;

    assign d_eff = CNT_W'(clamp_div(32'(div_q)));
    assign hi    = CNT_W'(high_time(32'(d_eff)));

`ifdef CLOCK_GEN_PHASE_EN
    logic [CNT_W-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (init_i) begin
            phase_d = '0;
        end else if (wr_i) begin
            phase_d = phase_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign p_eff = CNT_W'(clamp_phase(32'(phase_q), 32'(d_eff)));
`else
    logic unused_phase;
    assign unused_phase = ^phase_i;
    assign p_eff        = '0;
`endif

    always_comb begin
        div_d = div_q;
        if (init_i) begin
            div_d = DIV_RST;
        end else if (wr_i) begin
            div_d = div_i;
        end
    end

    // Counter holds 0 outside RUN; the final settle cycle seeds it with the phase.
    always_comb begin
        cnt_d = '0;
        if (load_i) begin
            cnt_d = p_eff;
        end else if (run_i) begin
            cnt_d = (cnt_q == d_eff - ONE) ? '0 : cnt_q + ONE;
        end
        outclk_d = (load_i || run_i) && (cnt_d < hi);
        tick_d   = (load_i || run_i) && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= DIV_RST;
            cnt_q    <= '0;
            outclk_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            outclk_q <= outclk_d;
            tick_q   <= tick_d;
        end
    end

    assign outclk_o = outclk_q;
    assign tick_o   = tick_q;

endmodule

// File: rtl/clock_gen.sv
// Multi-channel integer clock divider with settle/lock sequencing and runtime reprogramming.
// Define CLOCK_GEN_PHASE_EN to honour cfg_phase; otherwise all channels rise together.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int                         NUM_CLK     = 2,
    parameter int                         CNT_W       = CNT_W_DEF,
    parameter int                         LOCK_CYCLES = 16,
    parameter logic [NUM_CLK*CNT_W-1:0]   DIV_INIT    = {16'd4, 16'd20},
    localparam int                        CH_W        = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst_n,
    // cfg_valid/cfg_ready: a write is accepted on any refclk edge where both are high;
    // cfg_valid may be held without waiting for ready, and cfg_* must be stable while valid.
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [CNT_W-1:0]   cfg_phase,
    output logic [NUM_CLK-1:0] outclk,
    output logic [NUM_CLK-1:0] tick,
    output logic               locked,
    output logic [1:0]         fsm_state
);

    localparam int             SW          = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(LOCK_CYCLES - 1);

    state_t         state_q, state_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic           ready_q, locked_q;
    logic           wr_hit, settle_done, ch_load, ch_run, ch_init;

    // Out-of-range channel writes are accepted but change nothing.
    assign wr_hit      = cfg_valid && ready_q && (int'(cfg_ch) < NUM_CLK);
    assign settle_done = (state_q == ST_SETTLE) && (settle_q == SETTLE_LAST);
    assign ch_init     = (state_q == ST_INIT);
    assign ch_load     = settle_done && !wr_hit;
    assign ch_run      = (state_q == ST_RUN) && !wr_hit;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_INIT: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (wr_hit) begin
                    settle_d = '0;
                end else if (settle_done) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_RUN: begin
                if (wr_hit) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = ST_INIT;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            settle_q <= '0;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ready_q  <= (state_d != ST_INIT);
            locked_q <= (state_d == ST_RUN);
        end
    end

    assign cfg_ready = ready_q;
    assign locked    = locked_q;
    assign fsm_state = state_q;

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
        clock_gen_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_i    (refclk),
            .rst_ni   (rst_n),
            .init_i   (ch_init),
            .wr_i     (wr_hit && (cfg_ch == CH_W'(i))),
            .div_i    (cfg_div),
            .phase_i  (cfg_phase),
            .load_i   (ch_load),
            .run_i    (ch_run),
            .outclk_o (outclk[i]),
            .tick_o   (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: three channels so an out-of-range channel index exists.
module tb_clock_gen;

    localparam int NCH  = 3;
    localparam int CW   = 16;
    localparam int LOCK = 16;
    localparam int W    = 2 + 2 * NCH;

    logic            refclk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_ch;
    logic [CW-1:0]   cfg_div;
    logic [CW-1:0]   cfg_phase;
    logic [NCH-1:0]  outclk;
    logic [NCH-1:0]  tick;
    logic            locked;
    logic [1:0]      fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    clock_gen #(
        .NUM_CLK     (NCH),
        .CNT_W       (CW),
        .LOCK_CYCLES (LOCK),
        .DIV_INIT    ({16'd6, 16'd4, 16'd20})
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .outclk    (outclk),
        .tick      (tick),
        .locked    (locked),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state;  // 0 init, 1 settle, 2 run
    int m_scnt;
    int m_div[NCH];
    int m_ph[NCH];
    int m_cnt[NCH];
    int m_d[NCH];
    int def_div[NCH] = '{20, 4, 6};

    function automatic logic [W-1:0] model_vec();
        logic [NCH-1:0] o, t;
        o = '0;
        t = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m_state == 2) begin
                o[c] = (m_cnt[c] < (m_d[c] + 1) / 2);
                t[c] = (m_cnt[c] == 0);
            end
        end
        return {1'b1, (m_state == 2), t, o};
    endfunction

    task automatic model_step();
        bit hit;
        hit = cfg_valid && (m_state != 0) && (int'(cfg_ch) < NCH);
        if (m_state == 0) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = def_div[c];
                m_ph[c]  = 0;
                m_cnt[c] = 0;
            end
            m_state = 1;
            m_scnt  = 0;
        end else if (hit) begin
            m_div[cfg_ch] = int'(cfg_div);
            m_ph[cfg_ch]  = int'(cfg_phase);
            m_state = 1;
            m_scnt  = 0;
        end else if (m_state == 1) begin
            if (m_scnt == LOCK - 1) begin
                m_state = 2;
                for (int c = 0; c < NCH; c++) begin
                    m_d[c] = (m_div[c] < 2) ? 2 : m_div[c];
`ifdef CLOCK_GEN_PHASE_EN
                    m_cnt[c] = (m_ph[c] > m_d[c] - 1) ? m_d[c] - 1 : m_ph[c];
`else
                    m_cnt[c] = 0;
`endif
                end
            end else begin
                m_scnt++;
            end
        end else begin
            for (int c = 0; c < NCH; c++) m_cnt[c] = (m_cnt[c] + 1) % m_d[c];
        end
    endtask

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_scnt  = 0;
            exp_q.delete();
        end else begin
            model_step();
            exp_q.push_back(model_vec());
        end
    end

    // Scoreboard compare on the falling edge, away from the active edge.
    always @(negedge refclk) begin
        if (rst_n && exp_q.size() > 0) begin
            check("sb", 32'({cfg_ready, locked, tick, outclk}), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int ch, input int div, input int ph);
        @(negedge refclk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CW'(div);
        cfg_phase = CW'(ph);
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 300) begin
            @(negedge refclk);
            n++;
        end
        check("lock_wait", 32'(locked), 32'd1);
    endtask

    logic [31:0] pat_o[NCH];
    logic [31:0] pat_t[NCH];

    task automatic sample(input int len);
        for (int c = 0; c < NCH; c++) begin
            pat_o[c] = '0;
            pat_t[c] = '0;
        end
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < NCH; c++) begin
                pat_o[c] = {pat_o[c][30:0], outclk[c]};
                pat_t[c] = {pat_t[c][30:0], tick[c]};
            end
            @(negedge refclk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        repeat (3) @(negedge refclk);
        check("rst_outclk", 32'(outclk), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);

        rst_n = 1'b1;
        wait_lock(n);
        check("lock_edge", n, 17);
        sample(20);
        check("ch0_default", pat_o[0], 32'hFFC00);
        check("ch1_default", pat_o[1], 32'hCCCCC);
        check("ch1_tick", pat_t[1], 32'h88888);
        check("ch2_default", pat_o[2], 32'hE38E3);
        check("ch2_tick", pat_t[2], 32'h82082);

        cfg_write(0, 5, 0);
        check("wr_unlock", 32'(locked), 32'd0);
        check("wr_outclk_lo", 32'(outclk), 32'd0);
        wait_lock(n);
        check("relock", n, LOCK);
        sample(10);
        check("ch0_div5", pat_o[0], 32'h39C);
        check("ch1_realign", pat_o[1], 32'h333);

        cfg_write(1, 4, 2);
        wait_lock(n);
        sample(8);
`ifdef CLOCK_GEN_PHASE_EN
        check("ch1_phase", pat_o[1], 32'h33);
        check("ch1_phase_tick", pat_t[1], 32'h22);
`else
        check("ch1_phase", pat_o[1], 32'hCC);
        check("ch1_phase_tick", pat_t[1], 32'h88);
`endif
        check("ch0_tick_run0", pat_t[0], 32'h84);

        cfg_write(2, 0, 0);
        wait_lock(n);
        sample(6);
        check("div0_clk", pat_o[2], 32'h2A);
        check("div0_tick", pat_t[2], 32'h2A);
        cfg_write(2, 1, 0);
        wait_lock(n);
        sample(6);
        check("div1_clk", pat_o[2], 32'h2A);
        check("div1_tick", pat_t[2], 32'h2A);

        cfg_write(3, 9, 1);
        check("oob_ready", 32'(cfg_ready), 32'd1);
        repeat (3) @(negedge refclk);
        check("oob_locked", 32'(locked), 32'd1);

        cfg_write(0, 7, 0);
        repeat (5) @(negedge refclk);
        check("settle_mid", 32'(locked), 32'd0);
        cfg_write(0, 9, 0);
        wait_lock(n);
        check("resettle", n, LOCK);

        repeat (12) begin
            cfg_write($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12));
            repeat ($urandom_range(1, 25)) @(negedge refclk);
        end
        wait_lock(n);
        repeat (12) @(negedge refclk);

        @(posedge refclk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outclk", 32'(outclk), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd0);
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        wait_lock(n);
        check("relock_after_rst", n, 17);
        repeat (10) @(negedge refclk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
